// File: rtl/proc_pkg.sv
// Shared encodings for the multi-register control block: opcodes and FSM states.
package proc_pkg;

  typedef enum logic [2:0] {
    F_NOP  = 3'b000,
    F_LOAD = 3'b001,
    F_MOVE = 3'b010,
    F_ADD  = 3'b011,
    F_SUB  = 3'b100,
    F_XOR  = 3'b101,
    F_INC  = 3'b110,
    F_CLR  = 3'b111
  } func_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2,
    S_WB     = 2'd3
  } state_e;

endpackage

// File: rtl/reg_file.sv
// NREGS x DATA_W register file: one write port, NRD asynchronous read ports.
// Reads of an index beyond NREGS return zero.
module reg_file #(
  parameter int DATA_W = 4,
  parameter int NREGS  = 4,
  parameter int ADDR_W = $clog2(NREGS),
  parameter int NRD    = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          we,
  input  logic [ADDR_W-1:0]             waddr,
  input  logic [DATA_W-1:0]             wdata,
  input  logic [NRD-1:0][ADDR_W-1:0]    raddr,
  output logic [NRD-1:0][DATA_W-1:0]    rdata
);

  logic [NREGS-1:0][DATA_W-1:0] regs_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q <= '0;
    end else if (we) begin
      for (int i = 0; i < NREGS; i++)
        if (waddr == ADDR_W'(i)) regs_q[i] <= wdata;
    end
  end

  always_comb begin
    rdata = '0;
    for (int p = 0; p < NRD; p++)
      for (int i = 0; i < NREGS; i++)
        if (raddr[p] == ADDR_W'(i)) rdata[p] = regs_q[i];
  end

endmodule

// File: rtl/multi_reg_control.sv
// Four-state (IDLE/DECODE/EXEC/WB) register-transfer controller with ALU flags
// and two combinational display taps into the register file.
module multi_reg_control
  import proc_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int NREGS  = 4,
  parameter int ADDR_W = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        func,
  input  logic [ADDR_W-1:0] dst,
  input  logic [ADDR_W-1:0] src,
  input  logic [DATA_W-1:0] data,
  input  logic [ADDR_W-1:0] sel0,
  input  logic [ADDR_W-1:0] sel1,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              carry,
  output logic              zero,
  output logic [DATA_W-1:0] hex_reg0,
  output logic [DATA_W-1:0] hex_reg1
);

  localparam logic [ADDR_W:0] NREGS_L = (ADDR_W+1)'(NREGS);

  state_e              state_q, state_d;
  func_e               func_q;
  logic [ADDR_W-1:0]   dst_q, src_q;
  logic [DATA_W-1:0]   data_q, opa_q, opb_q;
  logic [DATA_W:0]     alu_d, res_q;
  logic                wr_q, err_q, carry_q, zero_q, oor;
  logic [3:0][ADDR_W-1:0] raddr;
  logic [3:0][DATA_W-1:0] rdata;

  assign oor = ({1'b0, dst_q} >= NREGS_L) || ({1'b0, src_q} >= NREGS_L);

  // Port order: operand dst, operand src, display 0, display 1.
  assign raddr = {sel1, sel0, src_q, dst_q};

  reg_file #(.DATA_W(DATA_W), .NREGS(NREGS), .ADDR_W(ADDR_W), .NRD(4)) u_rf (
    .clk   (clk),
    .rst_n (reset),
    .we    ((state_q == S_WB) && wr_q),
    .waddr (dst_q),
    .wdata (res_q[DATA_W-1:0]),
    .raddr (raddr),
    .rdata (rdata)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (start) state_d = S_DECODE;
      S_DECODE: state_d = S_EXEC;
      S_EXEC:   state_d = S_WB;
      S_WB:     state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Top bit of the result carries the adder carry-out, or the borrow for SUB.
  always_comb begin
    alu_d = '0;
    unique case (func_q)
      F_LOAD:  alu_d = {1'b0, data_q};
      F_MOVE:  alu_d = {1'b0, opb_q};
      F_ADD:   alu_d = {1'b0, opa_q} + {1'b0, opb_q};
      F_SUB:   alu_d = {1'b0, opa_q} - {1'b0, opb_q};
      F_XOR:   alu_d = {1'b0, opa_q ^ opb_q};
      F_INC:   alu_d = {1'b0, opa_q} + (DATA_W+1)'(1);
      default: alu_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      func_q  <= F_NOP;
      dst_q   <= '0;
      src_q   <= '0;
      data_q  <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      carry_q <= 1'b0;
      zero_q  <= 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE: if (start) begin
          func_q <= func_e'(func);
          dst_q  <= dst;
          src_q  <= src;
          data_q <= data;
          err_q  <= 1'b0;
        end
        S_DECODE: begin
          opa_q <= rdata[0];
          opb_q <= rdata[1];
        end
        S_EXEC: begin
          res_q <= alu_d;
          wr_q  <= (func_q != F_NOP) && !oor;
          if (oor) err_q <= 1'b1;
        end
        S_WB: if (wr_q) begin
          carry_q <= res_q[DATA_W];
          zero_q  <= (res_q[DATA_W-1:0] == '0);
        end
        default: ;
      endcase
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_WB);
  assign err      = err_q;
  assign carry    = carry_q;
  assign zero     = zero_q;
  assign hex_reg0 = rdata[2];
  assign hex_reg1 = rdata[3];

endmodule

// File: tb/tb_multi_reg_control.sv
// Bench: two instances (NREGS=4 and NREGS=3) share stimulus; each is checked
// against an array-based model of the register-transfer rules.
module tb_multi_reg_control;

  logic clk = 1'b0, reset = 1'b0, start = 1'b0;
  logic [2:0] func = '0;
  logic [1:0] dst = '0, src = '0, sel0 = '0, sel1 = '0;
  logic [3:0] data = '0;
  logic busy_a, done_a, err_a, carry_a, zero_a;
  logic busy_b, done_b, err_b, carry_b, zero_b;
  logic [3:0] h0_a, h1_a, h0_b, h1_b;

  int n_pass = 0, n_chk = 0;
  int m_regs[2][4];
  int m_err[2], m_c[2], m_z[2];
  int nr[2] = '{4, 3};

  always #5 clk = ~clk;

  multi_reg_control #(.DATA_W(4), .NREGS(4)) u_dut_a (
    .clk(clk), .reset(reset), .start(start), .func(func), .dst(dst), .src(src),
    .data(data), .sel0(sel0), .sel1(sel1), .busy(busy_a), .done(done_a),
    .err(err_a), .carry(carry_a), .zero(zero_a), .hex_reg0(h0_a), .hex_reg1(h1_a));

  multi_reg_control #(.DATA_W(4), .NREGS(3)) u_dut_b (
    .clk(clk), .reset(reset), .start(start), .func(func), .dst(dst), .src(src),
    .data(data), .sel0(sel0), .sel1(sel1), .busy(busy_b), .done(done_b),
    .err(err_b), .carry(carry_b), .zero(zero_b), .hex_reg0(h0_b), .hex_reg1(h1_b));

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++) m_regs[k][i] = 0;
      m_err[k] = 0; m_c[k] = 0; m_z[k] = 1;
    end
  endtask

  task automatic model_op(input int f, input int d, input int s, input int dat);
    int a, b, r, c;
    for (int k = 0; k < 2; k++) begin
      m_err[k] = (d >= nr[k] || s >= nr[k]) ? 1 : 0;
      if (f != 0 && m_err[k] == 0) begin
        a = m_regs[k][d];
        b = m_regs[k][s];
        c = 0;
        case (f)
          1: r = dat;
          2: r = b;
          3: begin r = a + b; c = (r > 15) ? 1 : 0; end
          4: begin c = (a < b) ? 1 : 0; r = a - b + 16; end
          5: r = a ^ b;
          6: begin r = a + 1; c = (r > 15) ? 1 : 0; end
          default: r = 0;
        endcase
        r = r % 16;
        m_regs[k][d] = r;
        m_c[k] = c;
        m_z[k] = (r == 0) ? 1 : 0;
      end
    end
  endtask

  function automatic int exp_reg(input int k, input int i);
    return (i < nr[k]) ? m_regs[k][i] : 0;
  endfunction

  // Sweeps the display selects over every index and compares flags; uses 4ns.
  task automatic check_state(input string tag);
    for (int i = 0; i < 4; i++) begin
      sel0 = 2'(i); sel1 = 2'(3 - i); #1;
      chk({tag, "_h0a"}, int'(h0_a), exp_reg(0, i));
      chk({tag, "_h1a"}, int'(h1_a), exp_reg(0, 3 - i));
      chk({tag, "_h0b"}, int'(h0_b), exp_reg(1, i));
      chk({tag, "_h1b"}, int'(h1_b), exp_reg(1, 3 - i));
    end
    chk({tag, "_busy"}, int'({busy_b, busy_a}), 0);
    chk({tag, "_flags_a"}, int'({err_a, carry_a, zero_a}), m_err[0]*4 + m_c[0]*2 + m_z[0]);
    chk({tag, "_flags_b"}, int'({err_b, carry_b, zero_b}), m_err[1]*4 + m_c[1]*2 + m_z[1]);
  endtask

  // Called at (or just after) a negedge; returns just after the negedge that
  // follows the write-back edge. Inputs are scrambled after acceptance.
  task automatic run_op(input string tag, input int f, input int d, input int s,
                        input int dat, input bit hold);
    start = 1'b1; func = 3'(f); dst = 2'(d); src = 2'(s); data = 4'(dat);
    @(negedge clk);
    chk({tag, "_acc_busy"}, int'({busy_b, busy_a}), 3);
    chk({tag, "_dec_done"}, int'({done_b, done_a}), 0);
    if (!hold) start = 1'b0;
    func = 3'($urandom); dst = 2'($urandom); src = 2'($urandom); data = 4'($urandom);
    @(negedge clk);
    chk({tag, "_exe_done"}, int'({done_b, done_a}), 0);
    func = 3'($urandom); data = 4'($urandom);
    @(negedge clk);
    chk({tag, "_wb_done"}, int'({done_b, done_a}), 3);
    @(negedge clk);
    chk({tag, "_post_done"}, int'({done_b, done_a}), 0);
    model_op(f, d, s, dat);
    check_state(tag);
  endtask

  task automatic peek(input int i0, input int i1);
    @(negedge clk);
    sel0 = 2'(i0); sel1 = 2'(i1); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    model_reset();
    #2;
    check_state("por");
    @(negedge clk);
    reset = 1'b1;

    run_op("ld0", 1, 0, 0, 'hA, 1'b0);
    run_op("ld1", 1, 1, 0, 'h7, 1'b0);
    peek(0, 1);
    chk("ld_hex0", int'(h0_a), 'hA);
    chk("ld_hex1", int'(h1_a), 'h7);

    run_op("add", 3, 0, 1, 0, 1'b0);
    chk("add_cz", int'({carry_a, zero_a}), 2);
    peek(0, 1);
    chk("add_r0", int'(h0_a), 1);
    run_op("subrr", 4, 1, 1, 0, 1'b0);
    chk("sub_cz", int'({carry_a, zero_a}), 1);
    peek(0, 1);
    chk("sub_r1", int'(h1_a), 0);

    run_op("ldf", 1, 2, 0, 'hF, 1'b0);
    run_op("inc", 6, 2, 0, 0, 1'b0);
    chk("inc_cz", int'({carry_a, zero_a}), 3);
    peek(2, 0);
    chk("inc_r2", int'(h0_a), 0);
    run_op("clr", 7, 0, 1, 0, 1'b0);
    chk("clr_c", int'(carry_a), 0);

    run_op("hold1", 1, 1, 0, 'h6, 1'b1);
    run_op("hold2", 5, 1, 3, 'h0, 1'b0);

    // Reset pulsed while LOAD r3=5 is in EXEC.
    start = 1'b1; func = 3'd1; dst = 2'd3; src = 2'd0; data = 4'd5;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b0; #1;
    chk("rst_busy", int'({busy_b, busy_a}), 0);
    chk("rst_done", int'({done_b, done_a}), 0);
    model_reset();
    @(negedge clk);
    chk("rst_hold_done", int'({done_b, done_a}), 0);
    reset = 1'b1;
    check_state("rst");

    run_op("oor", 1, 3, 0, 'h9, 1'b0);
    chk("oor_err", int'({err_b, err_a}), 2);
    run_op("clr_err", 1, 1, 2, 'h4, 1'b0);
    chk("clr_err_err", int'({err_b, err_a}), 0);
    run_op("nop", 0, 1, 2, 'h3, 1'b0);

    for (int n = 0; n < 40; n++)
      run_op("rnd", int'($urandom_range(7)), int'($urandom_range(3)),
             int'($urandom_range(3)), int'($urandom_range(15)), 1'($urandom));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
